// File: rtl/player_kinematics.sv
`default_nettype none
// ============================================================================
// player_kinematics : per-frame player motion with jump/gravity FSM, clamped
//                     position, animation divider and checkpoint/death/respawn
// Revision 1.0
// ============================================================================
module player_kinematics #(
   parameter int PW          = 10,
   parameter int VW          = 6,
   parameter int X_SPEED     = 2,
   parameter int JUMP_V      = 8,
   parameter int GRAVITY     = 1,
   parameter int MAX_FALL    = 6,
   parameter int MAX_JUMPS   = 2,
   parameter int ANIM_DIV    = 4,
   parameter int ANIM_FRAMES = 4,
   parameter int INIT_X      = 96,
   parameter int INIT_Y      = 192,
   parameter int X_MAX       = 608,
   parameter int Y_MAX       = 448,
   localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
   localparam int JW = $clog2(MAX_JUMPS + 1)
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          frame_clk,
   input  logic [1:0]    move,
   input  logic [3:0]    free,
   input  logic          jump,
   input  logic          dead,
   input  logic          check,
   input  logic          restart,
   input  logic [PW-1:0] map_x,
   input  logic [PW-1:0] map_y,
   output logic [PW-1:0] man_x,
   output logic [PW-1:0] man_y,
   output logic [1:0]    man_state,
   output logic [AW-1:0] anim_frame,
   output logic [JW-1:0] jumps_used,
   output logic          is_right,
   output logic          is_dead,
   output logic          checking
);

   localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic [PW-1:0]     c_init_x     = PW'(INIT_X);
   localparam logic [PW-1:0]     c_init_y     = PW'(INIT_Y);
   localparam logic [PW-1:0]     c_x_max      = PW'(X_MAX);
   localparam logic [PW-1:0]     c_y_max      = PW'(Y_MAX);
   localparam logic [PW-1:0]     c_x_speed    = PW'(X_SPEED);
   localparam logic [VW-1:0]     c_jump_vy    = VW'(-JUMP_V);
   localparam logic signed [VW:0] c_gravity   = (VW+1)'(GRAVITY);
   localparam logic signed [VW:0] c_max_fall  = (VW+1)'(MAX_FALL);
   localparam logic [JW-1:0]     c_max_jumps  = JW'(MAX_JUMPS);
   localparam logic [DW-1:0]     c_div_last   = DW'(ANIM_DIV - 1);
   localparam logic [AW-1:0]     c_frame_last = AW'(ANIM_FRAMES - 1);

   localparam logic [1:0] c_st_still = 2'b00;
   localparam logic [1:0] c_st_walk  = 2'b01;
   localparam logic [1:0] c_st_rise  = 2'b10;
   localparam logic [1:0] c_st_fall  = 2'b11;

   typedef enum logic [0:0] {GROUND = 1'b0, AIR = 1'b1} vstate_t;

   logic          fclk_q, fclk_d, jump_prev_q, jump_prev_d;
   logic [PW-1:0] x_q, x_d, y_q, y_d, cp_x_q, cp_x_d, cp_y_q, cp_y_d;
   logic [VW-1:0] vy_q, vy_d;
   vstate_t       vst_q, vst_d;
   logic [1:0]    mstate_q, mstate_d;
   logic [AW-1:0] anim_q, anim_d;
   logic [DW-1:0] div_q, div_d;
   logic [JW-1:0] jumps_q, jumps_d;
   logic          right_q, right_d, dead_q, dead_d, checking_q, checking_d;

   logic          tick, press, right_m;
   logic [PW:0]   x_sum;
   logic [PW+1:0] y_sum;
   logic [PW-1:0] x_m, y_step, y_m;
   logic [VW-1:0] vy_m;
   vstate_t       vst_m;
   logic [JW-1:0] jumps_m;
   logic [1:0]    mstate_m;
   logic [AW-1:0] anim_m;
   logic [DW-1:0] div_m;

   assign tick  = frame_clk & ~fclk_q;
   assign press = jump & ~jump_prev_q;

   function automatic logic [VW-1:0] fall_step(input logic [VW-1:0] v);
      logic signed [VW:0] s;
      s = $signed({v[VW-1], v}) + c_gravity;
      fall_step = (s > c_max_fall) ? c_max_fall[VW-1:0] : s[VW-1:0];
   endfunction

   // Candidate next state for a frame tick.
   always_comb begin
      right_m = right_q;
      x_m     = x_q;
      x_sum   = {1'b0, x_q} + {1'b0, c_x_speed};
      if (move == 2'b01) right_m = 1'b1;
      else if (move == 2'b10) right_m = 1'b0;
      if (move == 2'b01 && free[0])
         x_m = (x_sum > {1'b0, c_x_max}) ? c_x_max : x_sum[PW-1:0];
      else if (move == 2'b10 && free[1])
         x_m = (x_q < c_x_speed) ? '0 : x_q - c_x_speed;

      // Wide signed add so both underflow and overshoot are visible before clamping.
      y_sum  = {2'b00, y_q} + {{(PW+2-VW){vy_q[VW-1]}}, vy_q};
      y_step = y_sum[PW+1] ? '0 :
               (y_sum[PW:0] > {1'b0, c_y_max}) ? c_y_max : y_sum[PW-1:0];

      y_m     = y_q;
      vy_m    = vy_q;
      vst_m   = vst_q;
      jumps_m = jumps_q;
      if (vst_q == GROUND) begin
         if (press) begin
            vy_m = c_jump_vy; jumps_m = JW'(1); vst_m = AIR;
         end else if (free[3]) begin
            vy_m = '0; jumps_m = '0; vst_m = AIR;
         end
      end else if (press && jumps_q < c_max_jumps) begin
         vy_m = c_jump_vy; jumps_m = jumps_q + JW'(1);
      end else if (vy_q[VW-1]) begin
         if (free[2]) begin
            y_m = y_step; vy_m = fall_step(vy_q);
         end else begin
            vy_m = fall_step('0);
         end
      end else if (free[3]) begin
         y_m = y_step; vy_m = fall_step(vy_q);
      end else begin
         vy_m = '0; jumps_m = '0; vst_m = GROUND;
      end

      if (vst_m == AIR) mstate_m = vy_m[VW-1] ? c_st_rise : c_st_fall;
      else              mstate_m = (x_m != x_q) ? c_st_walk : c_st_still;

      anim_m = anim_q;
      div_m  = div_q;
      if (mstate_m != mstate_q) begin
         anim_m = '0; div_m = '0;
      end else if (div_q == c_div_last) begin
         div_m  = '0;
         anim_m = (anim_q == c_frame_last) ? '0 : anim_q + AW'(1);
      end else begin
         div_m = div_q + DW'(1);
      end
   end

   // Restart outranks death, which outranks tick motion.
   always_comb begin
      fclk_d      = frame_clk;
      checking_d  = check;
      cp_x_d      = check ? map_x : cp_x_q;
      cp_y_d      = check ? map_y : cp_y_q;
      jump_prev_d = jump_prev_q;
      x_d = x_q; y_d = y_q; vy_d = vy_q; vst_d = vst_q; mstate_d = mstate_q;
      anim_d = anim_q; div_d = div_q; jumps_d = jumps_q; right_d = right_q; dead_d = dead_q;
      if (restart) begin
         x_d = cp_x_q; y_d = cp_y_q; vy_d = '0; vst_d = GROUND; mstate_d = c_st_still;
         anim_d = '0; div_d = '0; jumps_d = '0; right_d = 1'b1; dead_d = 1'b0;
      end else if (dead) begin
         dead_d = 1'b1;
      end else if (tick && !dead_q) begin
         x_d = x_m; y_d = y_m; vy_d = vy_m; vst_d = vst_m; mstate_d = mstate_m;
         anim_d = anim_m; div_d = div_m; jumps_d = jumps_m; right_d = right_m;
         jump_prev_d = jump;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         fclk_q <= 1'b0; jump_prev_q <= 1'b0; checking_q <= 1'b0;
         x_q <= c_init_x; y_q <= c_init_y; cp_x_q <= c_init_x; cp_y_q <= c_init_y;
         vy_q <= '0; vst_q <= GROUND; mstate_q <= c_st_still;
         anim_q <= '0; div_q <= '0; jumps_q <= '0; right_q <= 1'b1; dead_q <= 1'b0;
      end else begin
         fclk_q <= fclk_d; jump_prev_q <= jump_prev_d; checking_q <= checking_d;
         x_q <= x_d; y_q <= y_d; cp_x_q <= cp_x_d; cp_y_q <= cp_y_d;
         vy_q <= vy_d; vst_q <= vst_d; mstate_q <= mstate_d;
         anim_q <= anim_d; div_q <= div_d; jumps_q <= jumps_d; right_q <= right_d; dead_q <= dead_d;
      end
   end

   assign man_x      = x_q;
   assign man_y      = y_q;
   assign man_state  = mstate_q;
   assign anim_frame = anim_q;
   assign jumps_used = jumps_q;
   assign is_right   = right_q;
   assign is_dead    = dead_q;
   assign checking   = checking_q;

endmodule
`default_nettype wire

// File: tb/tb_player_kinematics.sv
`default_nettype none
// tb_player_kinematics: directed and randomized stimulus; a scoreboard monitor
// compares every clock's outputs against a behavioural model of the player.
module tb_player_kinematics;

   localparam int X_SPEED = 2, JUMP_V = 8, GRAVITY = 1, MAX_FALL = 6, MAX_JUMPS = 2;
   localparam int ANIM_DIV = 4, ANIM_FRAMES = 4, INIT_X = 96, INIT_Y = 192;
   localparam int X_MAX = 608, Y_MAX = 448;

   logic       Clk = 1'b0;
   logic       Reset_n, frame_clk, jump, dead, check, restart;
   logic [1:0] move;
   logic [3:0] free;
   logic [9:0] map_x, map_y, man_x, man_y;
   logic [1:0] man_state, anim_frame, jumps_used;
   logic       is_right, is_dead, checking;

   player_kinematics dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .move(move), .free(free),
      .jump(jump), .dead(dead), .check(check), .restart(restart),
      .map_x(map_x), .map_y(map_y), .man_x(man_x), .man_y(man_y),
      .man_state(man_state), .anim_frame(anim_frame), .jumps_used(jumps_used),
      .is_right(is_right), .is_dead(is_dead), .checking(checking)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int due; int x; int y; int st; int anim; int jmp; int right; int dead; int chk;
   } exp_t;
   exp_t sb[$];

   int total = 0, bad = 0, cyc = 0;
   int rise_tbl[8] = '{184, 177, 171, 166, 162, 159, 157, 156};

   // Reference model state
   int mx, my, mvy, mj, mst, manim, mdiv, cpx, cpy;
   bit mair, mright, mdead, mchk, jprev, fcp;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_motion();
      bit pr;
      int nx, ny, nvy, nj, ns;
      bit nair;
      pr    = jump && !jprev;
      jprev = jump;
      if (move == 2'b10) mright = 0;
      if (move == 2'b01) mright = 1;
      nx = mx;
      if (move == 2'b01 && free[0]) nx = (mx + X_SPEED > X_MAX) ? X_MAX : mx + X_SPEED;
      else if (move == 2'b10 && free[1]) nx = (mx - X_SPEED < 0) ? 0 : mx - X_SPEED;
      ny = my; nvy = mvy; nair = mair; nj = mj;
      if (!mair) begin
         if (pr) begin nvy = -JUMP_V; nj = 1; nair = 1; end
         else if (free[3]) begin nvy = 0; nj = 0; nair = 1; end
      end else if (pr && mj < MAX_JUMPS) begin
         nvy = -JUMP_V; nj = mj + 1;
      end else if (mvy < 0) begin
         if (free[2]) ny = clampi(my + mvy, 0, Y_MAX);
         else nvy = 0;
         nvy = (nvy + GRAVITY > MAX_FALL) ? MAX_FALL : nvy + GRAVITY;
      end else if (free[3]) begin
         ny  = clampi(my + mvy, 0, Y_MAX);
         nvy = (mvy + GRAVITY > MAX_FALL) ? MAX_FALL : mvy + GRAVITY;
      end else begin
         nvy = 0; nj = 0; nair = 0;
      end
      ns = nair ? ((nvy < 0) ? 2 : 3) : ((nx != mx) ? 1 : 0);
      if (ns != mst) begin manim = 0; mdiv = 0; end
      else if (mdiv == ANIM_DIV - 1) begin mdiv = 0; manim = (manim + 1) % ANIM_FRAMES; end
      else mdiv = mdiv + 1;
      mx = nx; my = ny; mvy = nvy; mair = nair; mj = nj; mst = ns;
   endtask

   task automatic model_edge();
      bit tk;
      int ocx, ocy;
      if (!Reset_n) begin
         mx = INIT_X; my = INIT_Y; cpx = INIT_X; cpy = INIT_Y; mvy = 0; mair = 0;
         mst = 0; manim = 0; mdiv = 0; mj = 0; mright = 1; mdead = 0; mchk = 0;
         jprev = 0; fcp = 0;
      end else begin
         tk = frame_clk && !fcp;
         fcp = frame_clk;
         mchk = check;
         ocx = cpx; ocy = cpy;
         if (check) begin cpx = int'(map_x); cpy = int'(map_y); end
         if (restart) begin
            mx = ocx; my = ocy; mvy = 0; mair = 0; mst = 0; manim = 0; mdiv = 0;
            mj = 0; mright = 1; mdead = 0;
         end else if (dead) begin
            mdead = 1;
         end else if (tk && !mdead) begin
            model_motion();
         end
      end
   endtask

   // One clock edge with the current inputs; the expected outputs go to the scoreboard.
   task automatic edge_step();
      exp_t e;
      @(posedge Clk);
      #1;
      model_edge();
      e.due = cyc; e.x = mx; e.y = my; e.st = mst; e.anim = manim; e.jmp = mj;
      e.right = int'(mright); e.dead = int'(mdead); e.chk = int'(mchk);
      sb.push_back(e);
   endtask

   task automatic do_tick();
      frame_clk = 1'b1; edge_step();
      frame_clk = 1'b0; edge_step();
   endtask

   task automatic place(input int px, input int py);
      check = 1'b1; map_x = 10'(px); map_y = 10'(py); edge_step();
      check = 1'b0; restart = 1'b1; edge_step();
      restart = 1'b0;
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("due_cycle", cyc, e.due);
            chk("man_x", int'(man_x), e.x);
            chk("man_y", int'(man_y), e.y);
            chk("man_state", int'(man_state), e.st);
            chk("anim_frame", int'(anim_frame), e.anim);
            chk("jumps_used", int'(jumps_used), e.jmp);
            chk("is_right", int'(is_right), e.right);
            chk("is_dead", int'(is_dead), e.dead);
            chk("checking", int'(checking), e.chk);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int y_prev;
      Reset_n = 1'b0; frame_clk = 1'b0; move = 2'b00; free = 4'b0111; jump = 1'b0;
      dead = 1'b0; check = 1'b0; restart = 1'b0; map_x = '0; map_y = '0;
      edge_step();
      chk("rst_x", int'(man_x), 96); chk("rst_y", int'(man_y), 192);
      chk("rst_right", int'(is_right), 1);
      Reset_n = 1'b1;
      edge_step();

      // Jump arc from the ground
      jump = 1'b1;
      do_tick();
      chk("launch_y", int'(man_y), 192); chk("launch_st", int'(man_state), 2);
      for (int i = 0; i < 8; i++) begin
         do_tick();
         chk("rise_y", int'(man_y), rise_tbl[i]);
         chk("rise_st", int'(man_state), (i < 7) ? 2 : 3);
      end

      // Release, double jump at apex, third press ignored
      free = 4'b1111; jump = 1'b0; do_tick();
      chk("apex_y", int'(man_y), 156);
      jump = 1'b1; do_tick();
      chk("dbl_jumps", int'(jumps_used), 2); chk("dbl_st", int'(man_state), 2);
      chk("dbl_y", int'(man_y), 156);
      jump = 1'b0; do_tick();
      jump = 1'b1; do_tick();
      chk("third_jumps", int'(jumps_used), 2); chk("third_y", int'(man_y), 141);

      // Free fall saturates, then landing
      jump = 1'b0;
      repeat (19) do_tick();
      y_prev = int'(man_y);
      do_tick();
      chk("fall_max_step", int'(man_y) - y_prev, 6);
      y_prev = int'(man_y);
      free = 4'b0111; do_tick();
      chk("land_st", int'(man_state), 0); chk("land_jumps", int'(jumps_used), 0);
      chk("land_y", int'(man_y), y_prev);

      // Horizontal clamps and facing
      free = 4'b0000;
      place(1, 200);
      move = 2'b10; free = 4'b0010; do_tick();
      chk("left_clamp_x", int'(man_x), 0); chk("left_face", int'(is_right), 0);
      place(50, 200);
      free = 4'b0000; do_tick();
      chk("blocked_x", int'(man_x), 50); chk("blocked_face", int'(is_right), 0);
      place(607, 200);
      move = 2'b01; free = 4'b0001; do_tick();
      chk("right_clamp_x", int'(man_x), 608);
      do_tick();
      chk("right_hold_x", int'(man_x), 608);

      // Walk animation
      free = 4'b0000; move = 2'b00;
      place(100, 200);
      move = 2'b01; free = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         do_tick();
         chk("walk_st", int'(man_state), 1);
         chk("walk_anim", int'(anim_frame), i / 4);
      end
      move = 2'b00; do_tick();
      chk("stop_anim", int'(anim_frame), 0); chk("stop_st", int'(man_state), 0);

      // Checkpoint, death freeze, restart
      check = 1'b1; map_x = 10'd320; map_y = 10'd128; edge_step();
      check = 1'b0; dead = 1'b1; edge_step();
      dead = 1'b0; move = 2'b01; free = 4'b1111;
      repeat (5) do_tick();
      chk("frozen_x", int'(man_x), 124); chk("frozen_y", int'(man_y), 200);
      chk("frozen_dead", int'(is_dead), 1);
      move = 2'b00; free = 4'b0000;
      restart = 1'b1; check = 1'b1; map_x = '0; map_y = '0; edge_step();
      chk("respawn_x", int'(man_x), 320); chk("respawn_y", int'(man_y), 128);
      chk("respawn_dead", int'(is_dead), 0);
      check = 1'b0; edge_step();
      chk("new_cp_x", int'(man_x), 0); chk("new_cp_y", int'(man_y), 0);
      restart = 1'b0; dead = 1'b1; restart = 1'b1; edge_step();
      chk("dead_restart", int'(is_dead), 0);
      dead = 1'b0; restart = 1'b0;

      // Reset mid-jump
      free = 4'b0111; do_tick();
      jump = 1'b1; do_tick(); do_tick();
      chk("midjump_st", int'(man_state), 2);
      Reset_n = 1'b0; edge_step();
      chk("rst2_x", int'(man_x), 96); chk("rst2_y", int'(man_y), 192);
      chk("rst2_st", int'(man_state), 0); chk("rst2_jumps", int'(jumps_used), 0);
      Reset_n = 1'b1; jump = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         frame_clk = 1'($urandom_range(0, 1));
         move      = 2'($urandom_range(0, 3));
         free      = 4'($urandom_range(0, 15));
         jump      = 1'($urandom_range(0, 1));
         dead      = ($urandom_range(0, 99) < 2);
         restart   = ($urandom_range(0, 99) < 3);
         check     = ($urandom_range(0, 99) < 5);
         map_x     = 10'($urandom_range(0, 1023));
         map_y     = 10'($urandom_range(0, 1023));
         Reset_n   = ($urandom_range(0, 199) != 0);
         edge_step();
      end

      Reset_n = 1'b1; dead = 1'b0; restart = 1'b0; check = 1'b0; frame_clk = 1'b0;
      @(negedge Clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
